pc_fetch_unit: RTL

//   Fetch stage directly upstream of the IF/ID pipeline register. Owns the PC register, drives the

---
 rtl/pc_fetch_unit_if.sv | 29 ++
 rtl/pc_fetch_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction-memory request/ready handshake bundle
// Purpose: carries the fetch-side instruction-memory handshake.
// Signals:
//   imem_req_o   fetch unit -> memory  request
//   imem_addr_o  fetch unit -> memory  fetch address (the PC register)
//   imem_ready_i memory -> fetch unit  request accepted, data returned the same cycle
//   imem_data_i  memory -> fetch unit  instruction word, valid on req && ready
// Modports: master = fetch unit side, slave = memory side.

interface pc_fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_data_i
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch stage: PC register, imem handshake, redirects, IF/ID delivery
// Purpose: owns the PC, requests instructions, applies branch/jump redirects and
//   delivers {instr, PC+PC_INC, valid} to IF/ID while honouring the hazard stall.
// Ports:
//   clk, rst_i           clock and synchronous active-high reset
//   HD_i                 hazard stall shared with IF/ID
//   branch_i/_addr_i     taken branch and its target (wins over jump)
//   jump_i/_addr_i       jump and its target
//   imem                 instruction-memory handshake (pc_fetch_unit_if.master)
//   instr_o, add_pc_o    instruction and PC+PC_INC to IF/ID
//   valid_o, flush_o     real-instruction flag and IF/ID flush
//   fetch_cnt_o          consumed-instruction counter (PERF_CNT_EN)
//   bubble_cnt_o         bubble-cycle counter (PERF_CNT_EN)
// Build option: define PERF_CNT_EN to include the saturating performance counters;
//   otherwise both counter outputs are tied to zero.

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned PC_INC    = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 HD_i,
    input  logic                 branch_i,
    input  logic [31:0]          branch_addr_i,
    input  logic                 jump_i,
    input  logic [31:0]          jump_addr_i,
    pc_fetch_unit_if.master      imem,
    output logic [31:0]          instr_o,
    output logic [31:0]          add_pc_o,
    output logic                 valid_o,
    output logic                 flush_o,
    output logic [CNT_WIDTH-1:0] fetch_cnt_o,
    output logic [CNT_WIDTH-1:0] bubble_cnt_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_r, pc_nxt;
    logic [31:0] instr_buf_r, instr_buf_nxt;
    logic [31:0] tgt_r, tgt_nxt;

    logic        redir;
    logic [31:0] target;
    logic [31:0] pc_inc;
    logic        ready;
    logic        req_c;
    logic        valid_c;
    logic [31:0] instr_c;

    assign ready  = imem.imem_ready_i;
    assign redir  = branch_i | jump_i;
    // Targets are word aligned; low bits from the decoder are ignored.
    assign target = (branch_i ? branch_addr_i : jump_addr_i) & 32'hFFFF_FFFC;
    assign pc_inc = pc_r + 32'(PC_INC);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state       <= S_FETCH;
            pc_r        <= RESET_PC;
            instr_buf_r <= '0;
            tgt_r       <= '0;
        end else begin
            state       <= state_nxt;
            pc_r        <= pc_nxt;
            instr_buf_r <= instr_buf_nxt;
            tgt_r       <= tgt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc_r;
        instr_buf_nxt = instr_buf_r;
        tgt_nxt       = tgt_r;
        req_c         = 1'b0;
        valid_c       = 1'b0;
        instr_c       = imem.imem_data_i;

        case (state)
            S_FETCH: begin
                req_c   = 1'b1;
                valid_c = ready & ~redir;
                if (redir && ready) begin
                    pc_nxt = target;
                end else if (redir) begin
                    // The outstanding request keeps its address; remember where to go after it.
                    tgt_nxt   = target;
                    state_nxt = S_DROP;
                end else if (ready && !HD_i) begin
                    pc_nxt = pc_inc;
                end else if (ready) begin
                    // IF/ID is stalled: park the returned word until it is consumed.
                    instr_buf_nxt = imem.imem_data_i;
                    state_nxt     = S_HOLD;
                end
            end
            S_HOLD: begin
                valid_c = ~redir;
                instr_c = instr_buf_r;
                if (redir) begin
                    pc_nxt    = target;
                    state_nxt = S_FETCH;
                end else if (!HD_i) begin
                    pc_nxt    = pc_inc;
                    state_nxt = S_FETCH;
                end
            end
            S_DROP: begin
                req_c = 1'b1;
                if (redir) begin
                    tgt_nxt = target;
                end
                if (ready) begin
                    pc_nxt    = redir ? target : tgt_r;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    assign imem.imem_req_o  = req_c & ~rst_i;
    assign imem.imem_addr_o = pc_r;
    assign valid_o          = valid_c & ~rst_i;
    assign instr_o          = valid_o ? instr_c : 32'h0;
    assign flush_o          = redir & ~rst_i;
    assign add_pc_o         = pc_inc;

`ifdef PERF_CNT_EN
    logic [CNT_WIDTH-1:0] fetch_cnt_r;
    logic [CNT_WIDTH-1:0] bubble_cnt_r;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            fetch_cnt_r  <= '0;
            bubble_cnt_r <= '0;
        end else begin
            if (valid_o && !HD_i && fetch_cnt_r != '1) begin
                fetch_cnt_r <= fetch_cnt_r + 1'b1;
            end
            if (!valid_o && bubble_cnt_r != '1) begin
                bubble_cnt_r <= bubble_cnt_r + 1'b1;
            end
        end
    end

    assign fetch_cnt_o  = fetch_cnt_r;
    assign bubble_cnt_o = bubble_cnt_r;
`else
    assign fetch_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule
